// File: rtl/wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module : wb_arbiter                                                      |
// | Merges ALU and LSU results onto the regfile write port, formats loads.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int XLEN       = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            alu_valid_i,
   output logic            alu_ready_o,
   input  logic [4:0]      alu_rd_i,
   input  logic [XLEN-1:0] alu_data_i,
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [4:0]      lsu_rd_i,
   input  logic [2:0]      lsu_funct3_i,
   input  logic [1:0]      lsu_addr_lo_i,
   input  logic [XLEN-1:0] lsu_data_i,
   output logic            rd_we_o,
   output logic [4:0]      rd_addr_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            lsu_err_o,
   output logic [31:0]     wb_count_o
);

   localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);
   localparam logic [2:0]         c_F3_LB      = 3'b000;
   localparam logic [2:0]         c_F3_LH      = 3'b001;
   localparam logic [2:0]         c_F3_LW      = 3'b010;
   localparam logic [2:0]         c_F3_LBU     = 3'b100;
   localparam logic [2:0]         c_F3_LHU     = 3'b101;

   logic [c_CNT_W-1:0] r_starve;
   logic               r_rd_we;
   logic [4:0]         r_rd_addr;
   logic [XLEN-1:0]    r_rd_data;
   logic               r_lsu_err;
   logic [31:0]        r_wb_count;

   logic               w_force;
   logic               w_alu_fire;
   logic               w_lsu_fire;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [XLEN-1:0]    w_load_data;
   logic               w_illegal;
   logic               w_wr_valid;
   logic               w_wr_we;
   logic [4:0]         w_wr_rd;
   logic [XLEN-1:0]    w_wr_data;

   // A saturated starvation counter overrides the default LSU priority for one cycle.
   assign w_force     = (r_starve == c_STARVE_MAX);
   assign lsu_ready_o = ~w_force;
   assign alu_ready_o = ~lsu_valid_i | w_force;
   assign w_alu_fire  = alu_valid_i & alu_ready_o;
   assign w_lsu_fire  = lsu_valid_i & lsu_ready_o;

   assign w_byte = lsu_data_i[{lsu_addr_lo_i, 3'b000} +: 8];
   assign w_half = lsu_data_i[{lsu_addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      w_load_data = '0;
      w_illegal   = 1'b0;
      case (lsu_funct3_i)
         c_F3_LB:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         c_F3_LH:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
         c_F3_LW:  w_load_data = lsu_data_i;
         c_F3_LBU: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
         c_F3_LHU: w_load_data = {{(XLEN-16){1'b0}}, w_half};
         default:  w_illegal   = 1'b1;
      endcase
   end

   // Grants are exclusive, so the LSU select is enough to steer the write mux.
   assign w_wr_valid = w_alu_fire | w_lsu_fire;
   assign w_wr_rd    = w_lsu_fire ? lsu_rd_i : alu_rd_i;
   assign w_wr_data  = w_lsu_fire ? w_load_data : alu_data_i;
   assign w_wr_we    = w_wr_valid & (w_wr_rd != 5'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_starve   <= '0;
         r_rd_we    <= 1'b0;
         r_rd_addr  <= '0;
         r_rd_data  <= '0;
         r_lsu_err  <= 1'b0;
         r_wb_count <= '0;
      end else begin
         r_rd_we   <= w_wr_we;
         r_lsu_err <= w_lsu_fire & w_illegal;
         if (w_wr_valid) begin
            r_rd_addr <= w_wr_rd;
            r_rd_data <= w_wr_data;
         end
         if (w_wr_we) begin
            r_wb_count <= r_wb_count + 32'd1;
         end
         if (!alu_valid_i || w_alu_fire) begin
            r_starve <= '0;
         end else if (r_starve != c_STARVE_MAX) begin
            r_starve <= r_starve + c_CNT_W'(1);
         end
      end
   end

   assign rd_we_o    = r_rd_we;
   assign rd_addr_o  = r_rd_addr;
   assign rd_data_o  = r_rd_data;
   assign lsu_err_o  = r_lsu_err;
   assign wb_count_o = r_wb_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module : tb_wb_arbiter                                                   |
// | Self-checking bench for wb_arbiter with a behavioural reference model.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int XLEN       = 32;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            alu_valid_i;
   logic            alu_ready_o;
   logic [4:0]      alu_rd_i;
   logic [XLEN-1:0] alu_data_i;
   logic            lsu_valid_i;
   logic            lsu_ready_o;
   logic [4:0]      lsu_rd_i;
   logic [2:0]      lsu_funct3_i;
   logic [1:0]      lsu_addr_lo_i;
   logic [XLEN-1:0] lsu_data_i;
   logic            rd_we_o;
   logic [4:0]      rd_addr_o;
   logic [XLEN-1:0] rd_data_o;
   logic            lsu_err_o;
   logic [31:0]     wb_count_o;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: refusals since the ALU last got a grant, plus expected outputs.
   int          m_refused;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_err;
   logic [31:0] m_count;
   bit          m_af;
   bit          m_lf;

   always #5 clk = ~clk;

   wb_arbiter #(.STARVE_MAX(STARVE_MAX), .XLEN(XLEN)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .alu_valid_i  (alu_valid_i),
      .alu_ready_o  (alu_ready_o),
      .alu_rd_i     (alu_rd_i),
      .alu_data_i   (alu_data_i),
      .lsu_valid_i  (lsu_valid_i),
      .lsu_ready_o  (lsu_ready_o),
      .lsu_rd_i     (lsu_rd_i),
      .lsu_funct3_i (lsu_funct3_i),
      .lsu_addr_lo_i(lsu_addr_lo_i),
      .lsu_data_i   (lsu_data_i),
      .rd_we_o      (rd_we_o),
      .rd_addr_o    (rd_addr_o),
      .rd_data_o    (rd_data_o),
      .lsu_err_o    (lsu_err_o),
      .wb_count_o   (wb_count_o)
   );

   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'h1_0000  : h;
         3'd2:    return w;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit is_illegal(input logic [2:0] f3);
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   function automatic bit exp_force();
      return m_refused == STARVE_MAX;
   endfunction

   function automatic bit exp_alu_ready();
      return !lsu_valid_i || exp_force();
   endfunction

   function automatic bit exp_lsu_ready();
      return !exp_force();
   endfunction

   task automatic model_edge();
      bit af;
      bit lf;
      af = alu_valid_i && exp_alu_ready();
      lf = lsu_valid_i && exp_lsu_ready();
      m_af = 1'b0;
      m_lf = 1'b0;
      if (rst_i) begin
         m_refused = 0;
         m_we      = 1'b0;
         m_addr    = '0;
         m_data    = '0;
         m_err     = 1'b0;
         m_count   = '0;
      end else begin
         m_af  = af;
         m_lf  = lf;
         m_we  = 1'b0;
         m_err = 1'b0;
         if (lf) begin
            m_we   = (lsu_rd_i != 0);
            m_addr = lsu_rd_i;
            m_data = fmt_load(lsu_funct3_i, lsu_addr_lo_i, lsu_data_i);
            m_err  = is_illegal(lsu_funct3_i);
         end else if (af) begin
            m_we   = (alu_rd_i != 0);
            m_addr = alu_rd_i;
            m_data = alu_data_i;
         end
         if (m_we) m_count = m_count + 1;
         if (!alu_valid_i || af) m_refused = 0;
         else if (m_refused < STARVE_MAX) m_refused = m_refused + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_idle();
      alu_valid_i   = 1'b0;
      alu_rd_i      = '0;
      alu_data_i    = '0;
      lsu_valid_i   = 1'b0;
      lsu_rd_i      = '0;
      lsu_funct3_i  = '0;
      lsu_addr_lo_i = '0;
      lsu_data_i    = '0;
   endtask

   task automatic test_reset();
      set_idle();
      rst_i = 1'b1;
      tick();
      tick();
      n_cmp++; if (rd_we_o !== 1'b0)    begin n_err++; $display("FAIL reset_we got %0b want 0", rd_we_o); end
      n_cmp++; if (rd_addr_o !== 5'd0)  begin n_err++; $display("FAIL reset_addr got %0d want 0", rd_addr_o); end
      n_cmp++; if (rd_data_o !== 32'd0) begin n_err++; $display("FAIL reset_data got %h want 0", rd_data_o); end
      n_cmp++; if (lsu_err_o !== 1'b0)  begin n_err++; $display("FAIL reset_err got %0b want 0", lsu_err_o); end
      n_cmp++; if (wb_count_o !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", wb_count_o); end
      rst_i = 1'b0;
   endtask

   task automatic test_alu_single();
      alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'd10;
      #1;
      n_cmp++; if (alu_ready_o !== 1'b1) begin n_err++; $display("FAIL alu_ready got %0b want 1", alu_ready_o); end
      tick();
      alu_valid_i = 1'b0;
      n_cmp++; if (rd_we_o !== 1'b1)     begin n_err++; $display("FAIL alu_we got %0b want 1", rd_we_o); end
      n_cmp++; if (rd_addr_o !== 5'd1)   begin n_err++; $display("FAIL alu_addr got %0d want 1", rd_addr_o); end
      n_cmp++; if (rd_data_o !== 32'd10) begin n_err++; $display("FAIL alu_data got %0d want 10", rd_data_o); end
      n_cmp++; if (wb_count_o !== 32'd1) begin n_err++; $display("FAIL alu_count got %0d want 1", wb_count_o); end
      tick();
      n_cmp++; if (rd_we_o !== 1'b0)     begin n_err++; $display("FAIL alu_one_cycle got %0b want 0", rd_we_o); end
   endtask

   task automatic test_x0();
      alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hDEADBEEF;
      #1;
      n_cmp++; if (alu_ready_o !== 1'b1) begin n_err++; $display("FAIL x0_ready got %0b want 1", alu_ready_o); end
      tick();
      alu_valid_i = 1'b0;
      n_cmp++; if (rd_we_o !== 1'b0)     begin n_err++; $display("FAIL x0_we got %0b want 0", rd_we_o); end
      n_cmp++; if (wb_count_o !== 32'd1) begin n_err++; $display("FAIL x0_count got %0d want 1", wb_count_o); end
   endtask

   task automatic test_load_format();
      logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [1:0]  offs [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
      logic [31:0] exps [5] = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'hFFFF_8000,
                                32'h0000_F0A5, 32'h8000_F0A5};
      for (int i = 0; i < 5; i++) begin
         lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 32'h8000_F0A5;
         lsu_funct3_i = f3s[i]; lsu_addr_lo_i = offs[i];
         #1;
         n_cmp++; if (lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL ld%0d_ready got %0b want 1", i, lsu_ready_o); end
         tick();
         n_cmp++; if (rd_we_o !== 1'b1)     begin n_err++; $display("FAIL ld%0d_we got %0b want 1", i, rd_we_o); end
         n_cmp++; if (rd_addr_o !== 5'd3)   begin n_err++; $display("FAIL ld%0d_addr got %0d want 3", i, rd_addr_o); end
         n_cmp++; if (rd_data_o !== exps[i]) begin n_err++; $display("FAIL ld%0d_data got %h want %h", i, rd_data_o, exps[i]); end
         n_cmp++; if (lsu_err_o !== 1'b0)   begin n_err++; $display("FAIL ld%0d_err got %0b want 0", i, lsu_err_o); end
      end
      lsu_valid_i = 1'b0;
   endtask

   task automatic test_illegal();
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd4; lsu_funct3_i = 3'b011;
      lsu_addr_lo_i = 2'd0; lsu_data_i = 32'h1234_5678;
      tick();
      lsu_valid_i = 1'b0;
      n_cmp++; if (rd_we_o !== 1'b1)     begin n_err++; $display("FAIL ill_we got %0b want 1", rd_we_o); end
      n_cmp++; if (rd_addr_o !== 5'd4)   begin n_err++; $display("FAIL ill_addr got %0d want 4", rd_addr_o); end
      n_cmp++; if (rd_data_o !== 32'd0)  begin n_err++; $display("FAIL ill_data got %h want 0", rd_data_o); end
      n_cmp++; if (lsu_err_o !== 1'b1)   begin n_err++; $display("FAIL ill_err got %0b want 1", lsu_err_o); end
      tick();
      n_cmp++; if (lsu_err_o !== 1'b0)   begin n_err++; $display("FAIL ill_err_pulse got %0b want 0", lsu_err_o); end
   endtask

   task automatic test_contention();
      logic [31:0] base;
      bit          alu_turn;
      set_idle();
      tick();
      base = m_count;
      alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hA5A5_0001;
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd6; lsu_funct3_i = 3'b010; lsu_data_i = 32'h5A5A_0002;
      for (int i = 0; i < 10; i++) begin
         alu_turn = (i % 5 == 4);
         #1;
         n_cmp++; if (alu_ready_o !== alu_turn) begin n_err++; $display("FAIL cont%0d_alu_ready got %0b want %0b", i, alu_ready_o, alu_turn); end
         n_cmp++; if (lsu_ready_o !== !alu_turn) begin n_err++; $display("FAIL cont%0d_lsu_ready got %0b want %0b", i, lsu_ready_o, !alu_turn); end
         tick();
         n_cmp++; if (rd_we_o !== 1'b1) begin n_err++; $display("FAIL cont%0d_we got %0b want 1", i, rd_we_o); end
         n_cmp++; if (rd_addr_o !== (alu_turn ? 5'd5 : 5'd6)) begin n_err++; $display("FAIL cont%0d_addr got %0d want %0d", i, rd_addr_o, alu_turn ? 5 : 6); end
      end
      n_cmp++; if (wb_count_o !== base + 32'd10) begin n_err++; $display("FAIL cont_count got %0d want %0d", wb_count_o, base + 32'd10); end
      set_idle();
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (!alu_valid_i && ($urandom_range(0, 1) == 1)) begin
            alu_valid_i = 1'b1;
            alu_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu_data_i  = $urandom;
         end
         if (!lsu_valid_i && ($urandom_range(0, 2) != 0)) begin
            lsu_valid_i   = 1'b1;
            lsu_rd_i      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lsu_funct3_i  = 3'($urandom);
            lsu_addr_lo_i = 2'($urandom);
            lsu_data_i    = $urandom;
         end
         #1;
         n_cmp++; if (alu_ready_o !== exp_alu_ready()) begin n_err++; $display("FAIL rnd%0d_alu_ready got %0b want %0b", i, alu_ready_o, exp_alu_ready()); end
         n_cmp++; if (lsu_ready_o !== exp_lsu_ready()) begin n_err++; $display("FAIL rnd%0d_lsu_ready got %0b want %0b", i, lsu_ready_o, exp_lsu_ready()); end
         tick();
         n_cmp++; if (rd_we_o !== m_we) begin n_err++; $display("FAIL rnd%0d_we got %0b want %0b", i, rd_we_o, m_we); end
         if (m_we) begin
            n_cmp++; if (rd_addr_o !== m_addr) begin n_err++; $display("FAIL rnd%0d_addr got %0d want %0d", i, rd_addr_o, m_addr); end
            n_cmp++; if (rd_data_o !== m_data) begin n_err++; $display("FAIL rnd%0d_data got %h want %h", i, rd_data_o, m_data); end
         end
         n_cmp++; if (lsu_err_o !== m_err)    begin n_err++; $display("FAIL rnd%0d_err got %0b want %0b", i, lsu_err_o, m_err); end
         n_cmp++; if (wb_count_o !== m_count) begin n_err++; $display("FAIL rnd%0d_count got %0d want %0d", i, wb_count_o, m_count); end
         if (m_af) alu_valid_i = 1'b0;
         if (m_lf) lsu_valid_i = 1'b0;
      end
      set_idle();
      tick();
   endtask

   task automatic test_reset_mid();
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_funct3_i = 3'b010; lsu_data_i = 32'h0000_1234;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      lsu_valid_i = 1'b0;
      n_cmp++; if (rd_we_o !== 1'b0)     begin n_err++; $display("FAIL rstmid_we got %0b want 0", rd_we_o); end
      n_cmp++; if (rd_addr_o !== 5'd0)   begin n_err++; $display("FAIL rstmid_addr got %0d want 0", rd_addr_o); end
      n_cmp++; if (wb_count_o !== 32'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", wb_count_o); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (rd_we_o !== 1'b0)     begin n_err++; $display("FAIL rstmid_after%0d_we got %0b want 0", i, rd_we_o); end
         n_cmp++; if (wb_count_o !== 32'd0) begin n_err++; $display("FAIL rstmid_after%0d_count got %0d want 0", i, wb_count_o); end
      end
   endtask

   initial begin
      m_refused = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0; m_count = '0;
      m_af = 1'b0; m_lf = 1'b0;
      rst_i = 1'b1;
      set_idle();
      @(posedge clk);
      #1;
      test_reset();
      test_alu_single();
      test_x0();
      test_load_format();
      test_illegal();
      test_contention();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
